// File: rtl/reg2b_shift_out.sv
// Parallel-to-serial shifter with a one-word holding buffer so that a steady
// stream of words goes out back-to-back, one bit per enabled clock.
module reg2b_shift_out #(
  parameter int WIDTH     = 2,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             ser_q,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] buf_reg, buf_next;
  logic             buf_full_reg, buf_full_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             accept;
  logic             at_last;

  assign at_last   = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);
  assign in_ready  = !buf_full_reg;
  assign ser_valid = (state_reg == SHIFT);
  assign ser_last  = at_last;
  assign busy      = (state_reg == SHIFT) | buf_full_reg;
  // The outgoing bit always sits at the end of the shifter that leaves first.
  assign ser_q     = (state_reg == SHIFT) &&
                     (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    buf_next      = buf_reg;
    buf_full_next = buf_full_reg;
    cnt_next      = cnt_reg;
    accept        = in_valid && !buf_full_reg && clk_en;
    if (clk_en) begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_next = d;
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (at_last) begin
            cnt_next = '0;
            // Buffered word goes first; a full buffer also blocks any accept.
            if (buf_full_reg) begin
              shift_next    = buf_reg;
              buf_full_next = 1'b0;
            end else if (accept) begin
              shift_next = d;
            end else begin
              shift_next = '0;
              state_next = IDLE;
            end
          end else begin
            shift_next = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
            cnt_next   = cnt_reg + 1'b1;
            if (accept) begin
              buf_next      = d;
              buf_full_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      buf_reg      <= '0;
      buf_full_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      buf_reg      <= buf_next;
      buf_full_reg <= buf_full_next;
      cnt_reg      <= cnt_next;
    end
  end

endmodule

// File: doc/reg2b_shift_out.md
REG2B_SHIFT_OUT -- requirements
Module: reg2b_shift_out

Interface
REQ-001 Parameter WIDTH, default 2, bits per word.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clk_en  input  1  clock enable; when 0, all state is held.
REQ-006 in_valid  input  1  parallel word offered.
REQ-007 in_ready  output  1  block can accept a word; equals !buf_full.
REQ-008 d  input  WIDTH  parallel data word (for WIDTH=2: d[1]=d1, d[0]=d2).
REQ-009 ser_q  output  1  serial data bit.
REQ-010 ser_valid  output  1  ser_q carries a valid bit this cycle.
REQ-011 ser_last  output  1  ser_q is the final bit of the current word.
REQ-012 busy  output  1  shifter or buffer holds data.

Function
REQ-013 Accept occurs on a rising edge with in_valid=1, in_ready=1 and clk_en=1; d is sampled only at accept.
REQ-014 States: IDLE (shifter empty) and SHIFT (shifter holds a word); a one-word holding buffer with flag buf_full exists alongside.
REQ-015 IDLE and accept: word loads into shifter, bit count = 0, next state SHIFT; first bit appears on ser_q with ser_valid=1 in the cycle after the accepting edge (latency 1).
REQ-016 SHIFT, clk_en=1: each edge advances one bit; ser_last=1 when bit count = WIDTH-1.
REQ-017 At the edge ending the last bit: if buf_full, buffer moves into shifter, buf_full clears, state stays SHIFT, with no idle cycle between words.
REQ-018 At the edge ending the last bit, if buffer empty and accept occurs on the same edge, the incoming word loads the shifter directly and state stays SHIFT (no bubble).
REQ-019 At the edge ending the last bit, if buffer empty and no accept: next state IDLE, ser_valid=0.
REQ-020 In SHIFT, when not at a last-bit transfer, an accept writes the buffer and sets buf_full; in_ready drops the following cycle.
REQ-021 Bit order follows MSB_FIRST; the bit counter wraps 0..WIDTH-1 and never exceeds WIDTH-1.
REQ-022 clk_en=0: shifter, counter, buffer and state are frozen; outputs hold their values; no accept occurs even if in_valid=in_ready=1.
REQ-023 In IDLE, ser_q=0, ser_valid=0, ser_last=0.
REQ-024 busy = (state==SHIFT) | buf_full.
REQ-025 Sustained throughput: one word per WIDTH enabled cycles with no gaps while in_valid stays high.

Reset
REQ-026 reset=1 forces immediately, without a clock: state IDLE, buf_full=0, bit count 0, shifter and buffer 0.
REQ-027 During reset: ser_q=0, ser_valid=0, ser_last=0, busy=0, in_ready=1.
REQ-028 Reset asserted mid-word discards the shifter and buffer contents; the word is never resumed.
REQ-029 First accept can occur on the first rising edge after reset deasserts.

Verification
REQ-030 WIDTH=2, MSB_FIRST=1, d=2'b10 accepted in IDLE -> ser_q=1 then 0 on the next two cycles, ser_valid=1,1, ser_last=0,1, then IDLE.
REQ-031 Back-to-back: in_valid held with d=2'b11 then 2'b01 -> serial 1,1,0,1 over four contiguous cycles; in_ready=0 while the buffer is full.
REQ-032 clk_en=0 for 3 cycles after the first bit of 2'b10 -> ser_q holds 1, ser_valid holds 1; second bit 0 appears after clk_en returns to 1.
REQ-033 MSB_FIRST=0, d=2'b10 -> serial 0 then 1.
REQ-034 Reset pulsed between the cycles of 2'b11 -> ser_valid=0, busy=0, in_ready=1 immediately; after release, a new word 2'b01 is sent as 0,1.
REQ-035 Word accepted on the same edge that ends the last bit with the buffer empty -> next word starts the following cycle with no ser_valid gap.
